// File: rtl/mip_gen.sv
// mip_gen: interrupt-pending sources for the privileged unit.
// It synchronizes the external interrupt lines, runs mtime/mtimecmp, and holds the
// software pending bits. It registers the 12-bit MIP vector and flags new pending bits.
module mip_gen #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MTIME_W     = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               MExtIntIn,
  input  logic               SExtIntIn,
  input  logic               MTimeTick,
  input  logic               WrEn,
  input  logic [1:0]         WrSel,
  input  logic [31:0]        WrData,
  output logic [11:0]        MIP_REGW,
  output logic [MTIME_W-1:0] MTIME,
  output logic               IntRiseM
);

  logic [SYNC_STAGES-1:0] r_msync;
  logic [SYNC_STAGES-1:0] r_ssync;
  logic                   r_ssip;
  logic                   r_msip;
  logic                   r_stip;
  logic                   r_seipsw;
  logic [MTIME_W-1:0]     r_mtime;
  logic [MTIME_W-1:0]     r_mtimecmp;
  logic [MTIME_W-1:0]     w_mtimecmp_d;
  logic                   r_mtip;
  logic [11:0]            r_mip;
  logic [11:0]            r_mip_prev;
  logic [11:0]            w_mip_d;
  logic                   w_wr_cmp_lo;
  logic                   w_wr_cmp_hi;
  logic                   w_wr_sw;
  logic                   w_clr_mtime;
  logic                   w_meip;
  logic                   w_seip;

  assign w_wr_cmp_lo = WrEn & (WrSel == 2'b00);
  assign w_wr_cmp_hi = WrEn & (WrSel == 2'b01);
  assign w_wr_sw     = WrEn & (WrSel == 2'b10);
  assign w_clr_mtime = WrEn & (WrSel == 2'b11);

  // External-line synchronizer chains; the oldest stage is the synchronized level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_msync <= '0;
      r_ssync <= '0;
    end else begin
      r_msync <= {r_msync[SYNC_STAGES-2:0], MExtIntIn};
      r_ssync <= {r_ssync[SYNC_STAGES-2:0], SExtIntIn};
    end
  end

  // Software-settable pending bits, loaded only by a pending-bits write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ssip   <= 1'b0;
      r_msip   <= 1'b0;
      r_stip   <= 1'b0;
      r_seipsw <= 1'b0;
    end else if (w_wr_sw) begin
      r_ssip   <= WrData[1];
      r_msip   <= WrData[3];
      r_stip   <= WrData[5];
      r_seipsw <= WrData[9];
    end
  end

  // mtime counter: clear wins over a simultaneous tick, increment wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mtime <= '0;
    end else if (w_clr_mtime) begin
      r_mtime <= '0;
    end else if (MTimeTick) begin
      r_mtime <= r_mtime + MTIME_W'(1);
    end
  end

  // mtimecmp next value; each half is written on its own, the upper half only exists at 64 bits.
  if (MTIME_W > 32) begin : g_cmp_wide
    always_comb begin
      w_mtimecmp_d = r_mtimecmp;
      if (w_wr_cmp_lo) w_mtimecmp_d[31:0] = WrData;
      if (w_wr_cmp_hi) w_mtimecmp_d[MTIME_W-1:32] = WrData[MTIME_W-33:0];
    end
  end else begin : g_cmp_narrow
    always_comb begin
      w_mtimecmp_d = r_mtimecmp;
      if (w_wr_cmp_lo) w_mtimecmp_d = WrData[MTIME_W-1:0];
    end
  end

  // mtimecmp register, reset to all-ones so the timer interrupt starts inactive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mtimecmp <= '1;
    end else begin
      r_mtimecmp <= w_mtimecmp_d;
    end
  end

  // MTIP flop: unsigned compare on current register values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mtip <= 1'b0;
    end else begin
      r_mtip <= (r_mtime >= r_mtimecmp);
    end
  end

  assign w_meip = r_msync[SYNC_STAGES-1];
  assign w_seip = r_ssync[SYNC_STAGES-1] | r_seipsw;

  // Assemble the pending vector; unimplemented positions are tied to 0.
  always_comb begin
    w_mip_d     = '0;
    w_mip_d[11] = w_meip;
    w_mip_d[9]  = w_seip;
    w_mip_d[7]  = r_mtip;
    w_mip_d[5]  = r_stip;
    w_mip_d[3]  = r_msip;
    w_mip_d[1]  = r_ssip;
  end

  // Registered MIP vector and its one-cycle-delayed copy for rise detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mip      <= '0;
      r_mip_prev <= '0;
    end else begin
      r_mip      <= w_mip_d;
      r_mip_prev <= r_mip;
    end
  end

  assign MIP_REGW = r_mip;
  assign MTIME    = r_mtime;
  // Purely from registers, so there is no input-to-output path.
  assign IntRiseM = |(r_mip & ~r_mip_prev);

endmodule

// File: tb/tb_mip_gen.sv
// Self-checking bench for mip_gen: reset, vector table, hand sequences, randomized vs model.
module tb_mip_gen;

  localparam int unsigned S  = 2;
  localparam int unsigned W  = 64;
  localparam int          NR = 1500;

  logic          clk;
  logic          reset;
  logic          mext;
  logic          sext;
  logic          tick;
  logic          wr_en;
  logic [1:0]    wr_sel;
  logic [31:0]   wr_data;
  logic [11:0]   mip;
  logic [W-1:0]  mtime;
  logic          rise;

  int n_tests;
  int n_fail;

  typedef struct {
    logic        en;
    logic [1:0]  sel;
    logic [31:0] data;
    logic        tk;
    logic [11:0] mip;
    logic [63:0] mtime;
    logic        rise;
  } vec_t;

  vec_t vecs[18];

  // Reference-model histories, index = rising edge number after reset release.
  logic [63:0] mt_h  [0:NR];
  logic [63:0] cmp_h [0:NR];
  logic [11:0] sw_h  [0:NR];
  logic [11:0] mip_h [0:NR];
  logic        em_h  [0:NR];
  logic        es_h  [0:NR];
  logic [11:0] exp_mip;
  logic        exp_rise;
  int          r;

  mip_gen #(
    .SYNC_STAGES(S),
    .MTIME_W    (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MExtIntIn(mext),
    .SExtIntIn(sext),
    .MTimeTick(tick),
    .WrEn     (wr_en),
    .WrSel    (wr_sel),
    .WrData   (wr_data),
    .MIP_REGW (mip),
    .MTIME    (mtime),
    .IntRiseM (rise)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic en, input logic [1:0] sel, input logic [31:0] data,
                        input logic tk);
    wr_en   = en;
    wr_sel  = sel;
    wr_data = data;
    tick    = tk;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    mext    = 1'b0;
    sext    = 1'b0;
    set_in(1'b0, 2'b00, 32'h0, 1'b0);

    // {en, sel, data, tick, exp mip, exp mtime, exp rise}; one row per rising edge.
    vecs[0]  = '{1'b0, 2'b00, 32'h0000_0000, 1'b0, 12'h000, 64'd0, 1'b0};
    vecs[1]  = '{1'b1, 2'b10, 32'h0000_022A, 1'b0, 12'h000, 64'd0, 1'b0};
    vecs[2]  = '{1'b0, 2'b00, 32'h0000_0000, 1'b0, 12'h22A, 64'd0, 1'b1};
    vecs[3]  = '{1'b1, 2'b10, 32'h0000_0000, 1'b0, 12'h22A, 64'd0, 1'b0};
    vecs[4]  = '{1'b0, 2'b00, 32'h0000_0000, 1'b0, 12'h000, 64'd0, 1'b0};
    vecs[5]  = '{1'b1, 2'b10, 32'hFFFF_FFFF, 1'b0, 12'h000, 64'd0, 1'b0};
    vecs[6]  = '{1'b0, 2'b00, 32'h0000_0000, 1'b0, 12'h22A, 64'd0, 1'b1};
    vecs[7]  = '{1'b1, 2'b10, 32'h0000_0000, 1'b0, 12'h22A, 64'd0, 1'b0};
    vecs[8]  = '{1'b0, 2'b00, 32'h0000_0000, 1'b0, 12'h000, 64'd0, 1'b0};
    vecs[9]  = '{1'b1, 2'b00, 32'h0000_0002, 1'b0, 12'h000, 64'd0, 1'b0};
    vecs[10] = '{1'b1, 2'b01, 32'h0000_0000, 1'b0, 12'h000, 64'd0, 1'b0};
    vecs[11] = '{1'b0, 2'b00, 32'h0000_0000, 1'b1, 12'h000, 64'd1, 1'b0};
    vecs[12] = '{1'b0, 2'b00, 32'h0000_0000, 1'b1, 12'h000, 64'd2, 1'b0};
    vecs[13] = '{1'b0, 2'b00, 32'h0000_0000, 1'b0, 12'h000, 64'd2, 1'b0};
    vecs[14] = '{1'b0, 2'b00, 32'h0000_0000, 1'b0, 12'h080, 64'd2, 1'b1};
    vecs[15] = '{1'b1, 2'b11, 32'h0000_0000, 1'b1, 12'h080, 64'd0, 1'b0};
    vecs[16] = '{1'b0, 2'b00, 32'h0000_0000, 1'b0, 12'h080, 64'd0, 1'b0};
    vecs[17] = '{1'b0, 2'b00, 32'h0000_0000, 1'b0, 12'h000, 64'd0, 1'b0};

    // Reset held with random activity and ticking: everything stays at 0.
    #2 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mext = 1'($urandom);
      sext = 1'($urandom);
      set_in(1'($urandom), 2'($urandom), $urandom, 1'b1);
      step();
      check("rst_mip", 64'(mip), 64'h0);
      check("rst_mtime", 64'(mtime), 64'h0);
      check("rst_rise", 64'(rise), 64'h0);
    end
    set_in(1'b0, 2'b00, 32'h0, 1'b0);
    sext  = 1'b0;
    mext  = 1'b1;
    reset = 1'b1;
    for (int e = 1; e <= int'(S) + 2; e++) begin
      step();
      check("rel_meip", 64'(mip), (e >= int'(S) + 1) ? 64'h800 : 64'h0);
      check("rel_rise", 64'(rise), (e == int'(S) + 1) ? 64'h1 : 64'h0);
    end
    mext = 1'b0;
    for (int e = 1; e <= int'(S) + 1; e++) step();
    check("meip_drop", 64'(mip), 64'h0);

    // Vector table from a fresh reset.
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 18; i++) begin
      set_in(vecs[i].en, vecs[i].sel, vecs[i].data, vecs[i].tk);
      step();
      check($sformatf("vec%0d_mip", i), 64'(mip), 64'(vecs[i].mip));
      check($sformatf("vec%0d_mtime", i), 64'(mtime), vecs[i].mtime);
      check($sformatf("vec%0d_rise", i), 64'(rise), 64'(vecs[i].rise));
    end

    // Timer compare: mtimecmp=5, cleared, ticking continuously.
    set_in(1'b1, 2'b00, 32'd5, 1'b0);
    step();
    set_in(1'b1, 2'b11, 32'd0, 1'b0);
    step();
    set_in(1'b0, 2'b00, 32'd0, 1'b1);
    for (int e = 1; e <= 7; e++) begin
      step();
      if (e == 5) check("tmr_mtime5", 64'(mtime), 64'd5);
      if (e == 6) check("tmr_mtip_e6", 64'(mip[7]), 64'h0);
      if (e == 7) check("tmr_mtip_e7", 64'(mip[7]), 64'h1);
    end
    set_in(1'b1, 2'b00, 32'd100, 1'b0);
    step();
    set_in(1'b0, 2'b00, 32'd0, 1'b0);
    step();
    check("tmr_cmp100_n1", 64'(mip[7]), 64'h1);
    step();
    check("tmr_cmp100_n2", 64'(mip[7]), 64'h0);

    // Clear beats tick at mtime=1000.
    set_in(1'b0, 2'b00, 32'd0, 1'b1);
    for (int i = 0; i < 993; i++) step();
    check("cnt_1000", 64'(mtime), 64'd1000);
    set_in(1'b1, 2'b11, 32'd0, 1'b1);
    step();
    check("clr_vs_tick", 64'(mtime), 64'd0);
    set_in(1'b0, 2'b00, 32'd0, 1'b0);
    step();
    check("clr_hold", 64'(mtime), 64'd0);

    // Asynchronous reset mid-cycle while ticking and with pending bits set.
    set_in(1'b1, 2'b10, 32'h22A, 1'b1);
    step();
    set_in(1'b0, 2'b00, 32'd0, 1'b1);
    step();
    check("pre_arst_mip", 64'(mip), 64'h22A);
    #2 reset = 1'b0;
    #1;
    check("arst_mip", 64'(mip), 64'h0);
    check("arst_mtime", 64'(mtime), 64'h0);
    check("arst_rise", 64'(rise), 64'h0);
    set_in(1'b0, 2'b00, 32'd0, 1'b0);
    step();
    reset = 1'b1;

    // SEIP merge of the synchronized line and the software bit.
    set_in(1'b1, 2'b10, 32'h200, 1'b0);
    step();
    set_in(1'b0, 2'b00, 32'd0, 1'b0);
    step();
    check("seipsw_set", 64'(mip), 64'h200);
    for (int i = 0; i < 8 + int'(S); i++) begin
      sext = (i < 3);
      step();
      check("seip_pulse_bit9", 64'(mip[9]), 64'h1);
      check("seip_pulse_rise", 64'(rise), 64'h0);
    end
    sext = 1'b1;
    for (int i = 0; i < int'(S) + 2; i++) step();
    set_in(1'b1, 2'b10, 32'h0, 1'b0);
    step();
    set_in(1'b0, 2'b00, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("seip_ext_holds", 64'(mip[9]), 64'h1);
    end
    sext = 1'b0;
    for (int e = 1; e <= int'(S) + 1; e++) begin
      step();
      check("seip_drop", 64'(mip[9]), (e == int'(S) + 1) ? 64'h0 : 64'h1);
    end

    // Randomized run against a history-based reference model.
    reset = 1'b0;
    step();
    reset = 1'b1;
    mt_h[0]  = 64'd0;
    cmp_h[0] = '1;
    sw_h[0]  = 12'h0;
    mip_h[0] = 12'h0;
    em_h[0]  = 1'b0;
    es_h[0]  = 1'b0;
    for (int k = 1; k <= NR; k++) begin
      if ($urandom_range(0, 7) == 0) mext = ~mext;
      if ($urandom_range(0, 7) == 0) sext = ~sext;
      tick  = 1'($urandom);
      wr_en = ($urandom_range(0, 4) == 0);
      r = int'($urandom_range(0, 9));
      if (r <= 3) begin
        wr_sel  = 2'b00;
        wr_data = $urandom_range(0, 60);
      end else if (r == 4) begin
        wr_sel  = 2'b01;
        wr_data = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'h0;
      end else if (r <= 7) begin
        wr_sel  = 2'b10;
        wr_data = $urandom;
      end else begin
        wr_sel  = 2'b11;
        wr_data = $urandom;
      end

      em_h[k]  = mext;
      es_h[k]  = sext;
      if (wr_en && wr_sel == 2'b11) mt_h[k] = 64'd0;
      else if (tick)                mt_h[k] = mt_h[k-1] + 64'd1;
      else                          mt_h[k] = mt_h[k-1];
      cmp_h[k] = cmp_h[k-1];
      if (wr_en && wr_sel == 2'b00) cmp_h[k][31:0]  = wr_data;
      if (wr_en && wr_sel == 2'b01) cmp_h[k][63:32] = wr_data;
      sw_h[k]  = (wr_en && wr_sel == 2'b10) ? (wr_data[11:0] & 12'h22A) : sw_h[k-1];

      exp_mip = sw_h[k-1];
      if (k > int'(S)) begin
        exp_mip[11] = em_h[k-int'(S)];
        exp_mip[9]  = exp_mip[9] | es_h[k-int'(S)];
      end
      if (k >= 2 && mt_h[k-2] >= cmp_h[k-2]) exp_mip[7] = 1'b1;
      mip_h[k] = exp_mip;
      exp_rise = |(mip_h[k] & ~mip_h[k-1]);

      step();
      check($sformatf("rnd%0d_mip", k), 64'(mip), 64'(exp_mip));
      check($sformatf("rnd%0d_mtime", k), 64'(mtime), mt_h[k]);
      check($sformatf("rnd%0d_rise", k), 64'(rise), 64'(exp_rise));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mip_gen.md
# mip_gen

Interrupt-pending source block for the privileged unit. It synchronizes asynchronous external interrupt lines and runs the machine timer (mtime/mtimecmp). It holds the software-settable pending bits and presents the registered 12-bit MIP_REGW vector consumed by the trap logic. It also flags new pending interrupts so the pipeline can wake from wfi.

## Interface
Parameters:
- SYNC_STAGES, 2, flop depth of each external-interrupt synchronizer (legal 2..4)
- MTIME_W, 64, width of mtime and mtimecmp (legal 32 or 64)

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- MExtIntIn  in  1  machine external interrupt level from PLIC, asynchronous to clk
- SExtIntIn  in  1  supervisor external interrupt level from PLIC, asynchronous to clk
- MTimeTick  in  1  synchronous increment enable for mtime
- WrEn  in  1  register write strobe, one write per cycle
- WrSel  in  2  write target:
  - 00: mtimecmp[31:0]
  - 01: mtimecmp[MTIME_W-1:32] (ignored when MTIME_W=32)
  - 10: software pending bits
  - 11: clear mtime
- WrData  in  32  write data
- MIP_REGW  out  12  pending vector:
  - bit 11 MEIP, bit 9 SEIP, bit 7 MTIP, bit 5 STIP, bit 3 MSIP, bit 1 SSIP
  - all other bits are 0
- MTIME  out  MTIME_W  current mtime value
- IntRiseM  out  1  high for one cycle when any MIP_REGW bit rises 0->1

## Operation
Synchronizers:
- Each external line passes through SYNC_STAGES flops, all reset to 0.
- MEIP = synchronized MExtIntIn (level-sensitive, no latching).
- SEIP = synchronized SExtIntIn OR SEIPsw.

Software bits SSIP, MSIP, STIP, SEIPsw:
- Written only by WrEn & WrSel=10, from WrData[1], [3], [5], [9] respectively.
- All other WrData bits are ignored.
- Each bit holds its value until the next such write.

Timer:
- mtime increments by 1 on MTimeTick; it wraps from all-ones to 0.
- WrSel=11 forces mtime to 0. Clear has priority over a simultaneous MTimeTick.
- mtimecmp halves are written independently. No write touches the other half.
- MTIP is a flop loaded each cycle with (mtime >= mtimecmp), compared unsigned on current register values.

Output and rise detect:
- MIP_REGW is a registered vector assembled from the sources above. Unimplemented bits are tied to 0.
- IntRiseM = |(MIP_REGW & ~MipPrev), where MipPrev is MIP_REGW delayed one cycle (reset 0).

Reset values:
- MIP_REGW 0, MTIME 0, mtimecmp all-ones, IntRiseM 0.
- All software bits and synchronizer flops 0.
- Assertion of reset clears every register immediately, even mid-write or mid-tick. The first rising edge after deassertion behaves as normal operation.

## Timing
- External line to MIP_REGW: an edge sampled at rising edge N appears on MIP_REGW after edge N+SYNC_STAGES. Deassertion has the same latency.
- Software bit write at edge N: MIP_REGW reflects the new value after edge N+1; IntRiseM is high in that same cycle.
- mtimecmp write at edge N: register updated at N. MTIP flop samples the new compare at N+1. MIP_REGW[7] changes after N+2.
- MTimeTick at edge N: MTIME updated after N. If this crosses mtimecmp, MIP_REGW[7] rises two edges later.
- Wrap: mtime all-ones + tick -> 0. MTIP drops 2 cycles later unless mtimecmp = 0.
- Split 64-bit compare: software must write the high half to all-ones first to avoid a spurious MTIP. Hardware performs no write atomicity.
- IntRiseM is combinational from registered values only. It has no input-to-output path.
- Simultaneous events (e.g. external rise and software write in the same cycle):
  - All sources update independently.
  - IntRiseM stays a single cycle per rising cycle, irrespective of how many bits rose.

## Test plan
- Reset: hold reset=0 with random inputs and MTimeTick=1 -> MIP_REGW=0, MTIME=0, IntRiseM=0 throughout. Deassert with MExtIntIn=1 -> MIP_REGW=12'h800 exactly SYNC_STAGES+1 edges later, IntRiseM pulses once.
- Software bits:
  - WrSel=10, WrData=32'h22A -> next cycle MIP_REGW=12'h22A (SSIP, MSIP, STIP, SEIP).
  - Then WrData=0 -> 12'h000, with no IntRiseM pulse on the fall.
- Timer compare:
  - mtimecmp=5, mtime cleared, MTimeTick held high -> MTIME reaches 5 at edge 5 and MIP_REGW[7]=1 after edge 7.
  - Rewrite mtimecmp lo=100 -> bit 7 returns to 0 two edges later.
- Clear vs tick: WrSel=11 with MTimeTick=1 while mtime=1000 -> MTIME=0 next cycle, not 1.
- Wrap: force mtime to all-ones with mtimecmp=all-ones (MTIP=1), tick once -> MTIME=0 and MIP_REGW[7]=0 two cycles later.
- SEIP merge:
  - SEIPsw=1 plus SExtIntIn pulse -> bit 9 stays 1 throughout with no IntRiseM.
  - Clear SEIPsw while SExtIntIn=1 -> bit 9 stays 1.
  - Drop SExtIntIn -> bit 9 clears SYNC_STAGES+1 edges later.
